// File: rtl/price_pair_source_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | price_pair_source_if                                                 |
// | Price-in / pair-out valid-ready bundle for price_pair_source.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface price_pair_source_if;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_price;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_past_price;
  logic [15:0] o_actual_price;

  // slave: the pair source itself; master: the surrounding environment
  modport slave (
    input  i_valid, i_price, i_ready,
    output o_ready, o_valid, o_past_price, o_actual_price
  );
  modport master (
    output i_valid, i_price, i_ready,
    input  o_ready, o_valid, o_past_price, o_actual_price
  );
endinterface
`default_nettype wire

// File: rtl/price_pair_source.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | price_pair_source                                                    |
// | Turns a uq8_8 price stream into (past, actual) pairs G_LAG apart.    |
// | Optional synchronous flush port: define PRICE_PAIR_FLUSH_EN.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module price_pair_source #(
  parameter int G_LAG = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  price_pair_source_if.slave   bus,
  output logic                 o_primed
`ifdef PRICE_PAIR_FLUSH_EN
  ,
  input  logic                 i_flush
`endif
);

  localparam int CNT_W  = $clog2(G_LAG + 1);
  localparam int ADDR_W = (G_LAG > 1) ? $clog2(G_LAG) : 1;

  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   ptr_q, ptr_d;
  logic               valid_q, valid_d;
  logic [15:0]        past_q, past_d;
  logic [15:0]        act_q, act_d;
  logic [15:0]        hist_q [G_LAG];

  logic               w_flush;
  logic               w_ready;
  logic               w_accept;
  logic [15:0]        w_old;

`ifdef PRICE_PAIR_FLUSH_EN
  assign w_flush = i_flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_ready  = (!valid_q || bus.i_ready) && !w_flush;
  assign w_accept = bus.i_valid && w_ready;
  assign w_old    = hist_q[ptr_q[ADDR_W-1:0]];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    past_d  = past_q;
    act_d   = act_q;

    if (valid_q && bus.i_ready) begin
      valid_d = 1'b0;
    end

    if (w_accept) begin
      ptr_d = (ptr_q == CNT_W'(G_LAG - 1)) ? '0 : ptr_q + 1'b1;
      case (state_q)
        S_FILL: begin
          cnt_d = cnt_q + 1'b1;
          // the G_LAG-th accepted sample completes the history
          if (cnt_q == CNT_W'(G_LAG - 1)) begin
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          valid_d = 1'b1;
          past_d  = w_old;
          act_d   = bus.i_price;
        end
        default: state_d = S_FILL;
      endcase
    end

    if (w_flush) begin
      state_d = S_FILL;
      cnt_d   = '0;
      ptr_d   = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_FILL;
      cnt_q   <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      past_q  <= '0;
      act_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      past_q  <= past_d;
      act_q   <= act_d;
    end
  end

  // History contents are don't-care after reset, so no reset branch here
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      hist_q[ptr_q[ADDR_W-1:0]] <= bus.i_price;
    end
  end

  assign bus.o_ready        = w_ready;
  assign bus.o_valid        = valid_q;
  assign bus.o_past_price   = past_q;
  assign bus.o_actual_price = act_q;
  assign o_primed           = (state_q == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_price_pair_source.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_price_pair_source                                                 |
// | Three lanes (G_LAG = 1, 3, 2) checked against a queue scoreboard.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_price_pair_source;

  typedef logic [33:0] ent_t;  // {lane, past, actual}

  logic        clk = 1'b0;
  logic        rs   [3];
  logic        fl   [3];
  logic        vld  [3];
  logic [15:0] prc  [3];
  logic        rdy  [3];
  logic        ov   [3];
  logic        ordy [3];
  logic [15:0] opast[3];
  logic [15:0] oact [3];
  logic        opr  [3];
  logic        pr0, pr1, pr2;

  int          n_tot = 0;
  int          n_bad = 0;
  ent_t        sb[$];
  logic [15:0] mh [3][128];
  int          mn [3];
  logic        mv [3];
  logic        m_acc;

  price_pair_source_if if0 ();
  price_pair_source_if if1 ();
  price_pair_source_if if2 ();

  assign if0.i_valid = vld[0]; assign if0.i_price = prc[0]; assign if0.i_ready = rdy[0];
  assign if1.i_valid = vld[1]; assign if1.i_price = prc[1]; assign if1.i_ready = rdy[1];
  assign if2.i_valid = vld[2]; assign if2.i_price = prc[2]; assign if2.i_ready = rdy[2];

  assign ov[0] = if0.o_valid; assign ordy[0] = if0.o_ready;
  assign opast[0] = if0.o_past_price; assign oact[0] = if0.o_actual_price;
  assign ov[1] = if1.o_valid; assign ordy[1] = if1.o_ready;
  assign opast[1] = if1.o_past_price; assign oact[1] = if1.o_actual_price;
  assign ov[2] = if2.o_valid; assign ordy[2] = if2.o_ready;
  assign opast[2] = if2.o_past_price; assign oact[2] = if2.o_actual_price;
  assign opr[0] = pr0; assign opr[1] = pr1; assign opr[2] = pr2;

  price_pair_source #(.G_LAG(1)) u_dut0 (
    .i_clk(clk), .i_rst(rs[0]), .bus(if0.slave), .o_primed(pr0)
`ifdef PRICE_PAIR_FLUSH_EN
    , .i_flush(fl[0])
`endif
  );
  price_pair_source #(.G_LAG(3)) u_dut1 (
    .i_clk(clk), .i_rst(rs[1]), .bus(if1.slave), .o_primed(pr1)
`ifdef PRICE_PAIR_FLUSH_EN
    , .i_flush(fl[1])
`endif
  );
  price_pair_source #(.G_LAG(2)) u_dut2 (
    .i_clk(clk), .i_rst(rs[2]), .bus(if2.slave), .o_primed(pr2)
`ifdef PRICE_PAIR_FLUSH_EN
    , .i_flush(fl[2])
`endif
  );

  always #5 clk = ~clk;

  function automatic int lag_of(int k);
    case (k)
      0:       return 1;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive(int k, logic v, logic [15:0] p, logic r);
    @(posedge clk);
    #2;
    vld[k] = v;
    prc[k] = p;
    rdy[k] = r;
  endtask

  // Model on the rising edge, monitor on the falling edge
  always @(clk) begin
    if (clk) begin
      for (int k = 0; k < 3; k++) begin
        if (rs[k] || fl[k]) begin
          mn[k] = 0;
          mv[k] = 1'b0;
          for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i][33:32] == 2'(k)) sb.delete(i);
        end else begin
          m_acc = vld[k] && (!mv[k] || rdy[k]);
          if (mv[k] && rdy[k]) mv[k] = 1'b0;
          if (m_acc) begin
            mh[k][mn[k] % 128] = prc[k];
            if (mn[k] >= lag_of(k)) begin
              sb.push_back({2'(k), mh[k][(mn[k] - lag_of(k)) % 128], prc[k]});
              mv[k] = 1'b1;
            end
            mn[k]++;
          end
        end
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (rs[k] === 1'b0) begin
          chk($sformatf("valid%0d", k), 64'(ov[k]), 64'(mv[k]));
          chk($sformatf("ready%0d", k), 64'(ordy[k]), 64'((!mv[k] || rdy[k]) && !fl[k]));
          chk($sformatf("primed%0d", k), 64'(opr[k]), 64'(mn[k] >= lag_of(k)));
          if (mv[k]) begin
            chk($sformatf("pending%0d", k), 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
              chk($sformatf("pair%0d", k), 64'({2'(k), opast[k], oact[k]}), 64'(sb[0]));
              if (rdy[k]) void'(sb.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      rs[k] = 1'b1; fl[k] = 1'b0; vld[k] = 1'b0; prc[k] = '0; rdy[k] = 1'b1;
      mn[k] = 0; mv[k] = 1'b0;
    end
    @(posedge clk); @(posedge clk); #3;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_valid%0d", k), 64'(ov[k]), 64'd0);
      chk($sformatf("rst_past%0d", k), 64'(opast[k]), 64'd0);
      chk($sformatf("rst_act%0d", k), 64'(oact[k]), 64'd0);
      chk($sformatf("rst_primed%0d", k), 64'(opr[k]), 64'd0);
    end
    @(posedge clk); #2;
    for (int k = 0; k < 3; k++) rs[k] = 1'b0;

    // G_LAG=1: consecutive pairs
    drive(0, 1'b1, 16'h0100, 1'b1);
    drive(0, 1'b1, 16'h0180, 1'b1);
    drive(0, 1'b1, 16'h0140, 1'b1);
    repeat (3) drive(0, 1'b0, 16'h0000, 1'b1);

    // G_LAG=3: back-to-back with pointer wrap
    for (int i = 1; i <= 7; i++) drive(1, 1'b1, 16'(i), 1'b1);
    // backpressure with a held input, then release
    repeat (4) drive(1, 1'b1, 16'd8, 1'b0);
    drive(1, 1'b1, 16'd8, 1'b1);
    repeat (3) drive(1, 1'b0, 16'h0000, 1'b1);

    // randomised handshakes on the G_LAG=3 lane
    for (int i = 0; i < 60; i++)
      drive(1, 1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(0, 3) != 0);
    repeat (3) drive(1, 1'b0, 16'h0000, 1'b1);

    // G_LAG=2: async reset mid-stream with a held pair
    for (int i = 1; i <= 4; i++) drive(2, 1'b1, 16'(i), 1'b1);
    drive(2, 1'b1, 16'd5, 1'b0);
    @(posedge clk); #7;
    vld[2] = 1'b0;
    rs[2]  = 1'b1;
    #1;
    chk("arst_valid", 64'(ov[2]), 64'd0);
    chk("arst_past", 64'(opast[2]), 64'd0);
    chk("arst_act", 64'(oact[2]), 64'd0);
    chk("arst_primed", 64'(opr[2]), 64'd0);
    chk("arst_ready", 64'(ordy[2]), 64'd1);
    @(posedge clk); #2;
    rs[2] = 1'b0;
    drive(2, 1'b1, 16'd7, 1'b1);
    drive(2, 1'b1, 16'd8, 1'b1);
    drive(2, 1'b1, 16'd9, 1'b1);
    repeat (3) drive(2, 1'b0, 16'h0000, 1'b1);

`ifdef PRICE_PAIR_FLUSH_EN
    drive(0, 1'b1, 16'h0300, 1'b1);
    @(posedge clk); #2;
    fl[0] = 1'b1; vld[0] = 1'b1; prc[0] = 16'h0333; rdy[0] = 1'b1;
    @(posedge clk); #2;
    fl[0] = 1'b0; vld[0] = 1'b0;
    chk("flush_valid", 64'(ov[0]), 64'd0);
    chk("flush_primed", 64'(opr[0]), 64'd0);
    drive(0, 1'b1, 16'h0200, 1'b1);
    drive(0, 1'b1, 16'h0210, 1'b1);
    repeat (3) drive(0, 1'b0, 16'h0000, 1'b1);
`endif

    repeat (3) @(posedge clk);
    #3;
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
